// File: rtl/pc_seq_pkg.sv
// Shared types and opcode constants for the PC sequencer.
// Holds the FSM state enum and the opcode encoding seen from the IR.
package pc_seq_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    localparam logic [OPC_W-1:0] OP_ALU   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd2;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'd3;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'd4;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd15;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its datapath neighbours.
// master: sequencer (drives requests/strobes/pc); slave: memories, IR, ALU.
interface pc_sequencer_if #(
    parameter int PC_W = 6
);
    import pc_seq_pkg::*;

    logic             start;
    logic             imem_req;
    logic             imem_ack;
    logic             ir_load;
    logic [OPC_W-1:0] opcode;
    logic             branch_taken;
    logic [PC_W-1:0]  target;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             rf_we;
    logic [PC_W-1:0]  pc;
    logic             halted;

    modport master (
        input  start, imem_ack, opcode, branch_taken, target, dmem_ack,
        output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc, halted
    );

    modport slave (
        output start, imem_ack, opcode, branch_taken, target, dmem_ack,
        input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc, halted
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: sync clear, load of a target, wrapping increment.
// Ports: clk, clr, load (priority), inc, d (target), q (pc).
module pc_reg #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            // natural overflow gives modulo 2**PC_W
            q <= q + PC_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and next-PC choice.
// Ports: clk, rst (sync, active high), bus (master side of pc_sequencer_if).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_t           state;
    state_t           state_nx;
    logic [OPC_W-1:0] op_q;
    logic             pc_load;
    logic             pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nx = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) state_nx = DECODE;
            end
            DECODE: begin
                // opcode is live here; EXEC onward uses op_q
                if (bus.opcode == OP_HALT) begin
                    state_nx = HALTED;
                end else if (bus.opcode == OP_JMP) begin
                    pc_load  = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ALU: state_nx = WB;
                    OP_LOAD,
                    OP_STORE: state_nx = MEM;
                    OP_BEQ: begin
                        pc_load  = bus.branch_taken;
                        pc_inc   = !bus.branch_taken;
                        state_nx = FETCH;
                    end
                    default: begin
                        pc_inc   = 1'b1;
                        state_nx = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (bus.dmem_ack) begin
                    if (op_q == OP_STORE) begin
                        pc_inc   = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                pc_inc   = 1'b1;
                state_nx = FETCH;
            end
            HALTED: state_nx = HALTED;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.imem_req = (state == FETCH);
    assign bus.ir_load  = (state == FETCH) && bus.imem_ack;
    assign bus.dmem_req = (state == MEM);
    assign bus.dmem_we  = (state == MEM) && (op_q == OP_STORE);
    assign bus.rf_we    = (state == WB);
    assign bus.halted   = (state == HALTED);

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk  (clk),
        .clr  (rst),
        .load (pc_load),
        .inc  (pc_inc),
        .d    (bus.target),
        .q    (bus.pc)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction-level model plus directed runs.
// Ports: none (top-level bench).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_MEM   = 4;
    localparam int P_WB    = 5;
    localparam int P_HALT  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(6)) bus ();

    pc_sequencer #(.PC_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // memory responders: ack after a programmable number of wait cycles
    int imem_dly = 0;
    int dmem_dly = 0;
    int icnt = 0;
    int dcnt = 0;
    bit spur = 1'b0;

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.imem_req === 1'b1) begin
                bus.imem_ack = spur || (icnt == imem_dly);
                icnt++;
            end else begin
                bus.imem_ack = spur;
                icnt = 0;
            end
            if (bus.dmem_req === 1'b1) begin
                bus.dmem_ack = spur || (dcnt == dmem_dly);
                dcnt++;
            end else begin
                bus.dmem_ack = spur;
                dcnt = 0;
            end
        end
    end

    // instruction-level model: each instruction is a list of phases,
    // the PC effect is applied when the list runs out
    int m_ph = P_IDLE;
    int m_pc = 0;
    int m_op = 0;
    int m_tgt = 0;
    bit m_taken = 1'b0;
    int m_done = 0;
    int m_q[$];
    bit chk_en = 1'b0;

    bit cnt_en = 1'b0;
    int c_ireq, c_irl, c_dreq, c_dwe, c_rfwe;

    task automatic end_phase();
        if (m_q.size() == 0) begin
            if (m_op == int'(OP_BEQ) && m_taken) m_pc = m_tgt;
            else m_pc = (m_pc + 1) % 64;
            m_ph = P_FETCH;
            m_done++;
        end else begin
            m_ph = m_q.pop_front();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("imem_req", bus.imem_req, m_ph == P_FETCH);
                chk("ir_load", bus.ir_load,
                    m_ph == P_FETCH && bus.imem_ack);
                chk("dmem_req", bus.dmem_req, m_ph == P_MEM);
                chk("dmem_we", bus.dmem_we,
                    m_ph == P_MEM && m_op == int'(OP_STORE));
                chk("rf_we", bus.rf_we, m_ph == P_WB);
                chk("halted", bus.halted, m_ph == P_HALT);
                chk("pc", bus.pc, m_pc);
            end
            if (cnt_en) begin
                c_ireq += int'(bus.imem_req);
                c_irl  += int'(bus.ir_load);
                c_dreq += int'(bus.dmem_req);
                c_dwe  += int'(bus.dmem_we);
                c_rfwe += int'(bus.rf_we);
            end
            if (rst) begin
                m_ph = P_IDLE;
                m_pc = 0;
                m_op = 0;
                m_q.delete();
            end else begin
                case (m_ph)
                    P_IDLE: if (bus.start) m_ph = P_FETCH;
                    P_FETCH: if (bus.imem_ack) m_ph = P_DEC;
                    P_DEC: begin
                        m_op = int'(bus.opcode);
                        m_q.delete();
                        if (m_op == int'(OP_HALT)) begin
                            m_ph = P_HALT;
                        end else if (m_op == int'(OP_JMP)) begin
                            m_pc = int'(bus.target);
                            m_ph = P_FETCH;
                            m_done++;
                        end else begin
                            m_q.push_back(P_EXEC);
                            if (m_op == int'(OP_LOAD) ||
                                m_op == int'(OP_STORE))
                                m_q.push_back(P_MEM);
                            if (m_op == int'(OP_ALU) ||
                                m_op == int'(OP_LOAD))
                                m_q.push_back(P_WB);
                            m_ph = m_q.pop_front();
                        end
                    end
                    P_EXEC: begin
                        m_taken = bus.branch_taken;
                        m_tgt = int'(bus.target);
                        end_phase();
                    end
                    P_MEM: if (bus.dmem_ack) end_phase();
                    P_WB: end_phase();
                    default: ;
                endcase
            end
        end
    end

    // one instruction, entered in its first FETCH cycle
    task automatic run(input logic [3:0] op, input int tgt, input bit tk,
                       input int id, input int dd, input int lat,
                       input int epc, input string nm);
        int d0;
        int n;
        d0 = m_done;
        n = 0;
        bus.opcode = op;
        bus.target = 6'(tgt);
        bus.branch_taken = tk;
        imem_dly = id;
        dmem_dly = dd;
        c_ireq = 0;
        c_irl = 0;
        c_dreq = 0;
        c_dwe = 0;
        c_rfwe = 0;
        cnt_en = 1'b1;
        while (m_done == d0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cnt_en = 1'b0;
        chk({nm, " latency"}, n, lat);
        chk({nm, " pc"}, bus.pc, epc);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.opcode = OP_ALU;
        bus.target = '0;
        bus.branch_taken = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset pc", bus.pc, 0);
        chk("reset imem_req", bus.imem_req, 0);
        chk("reset dmem_req", bus.dmem_req, 0);
        chk("reset rf_we", bus.rf_we, 0);
        chk("reset halted", bus.halted, 0);

        pulse_start();
        run(OP_ALU, 0, 0, 0, 0, 4, 1, "alu");
        chk("alu rf_we pulses", c_rfwe, 1);
        run(OP_ALU, 0, 0, 3, 0, 7, 2, "alu_iwait");
        chk("iwait imem_req cycles", c_ireq, 4);
        chk("iwait ir_load pulses", c_irl, 1);
        run(OP_BEQ, 42, 1, 0, 0, 3, 42, "beq_taken");
        run(OP_JMP, 5, 0, 0, 0, 2, 5, "jmp5");
        run(OP_BEQ, 42, 0, 0, 0, 3, 6, "beq_not");
        run(OP_LOAD, 0, 0, 0, 2, 7, 7, "load");
        chk("load dmem_req cycles", c_dreq, 3);
        chk("load dmem_we cycles", c_dwe, 0);
        chk("load rf_we pulses", c_rfwe, 1);
        run(OP_STORE, 0, 0, 0, 0, 4, 8, "store");
        chk("store dmem_we cycles", c_dwe, 1);
        chk("store rf_we pulses", c_rfwe, 0);
        run(4'd7, 0, 0, 0, 0, 3, 9, "nop");
        run(OP_JMP, 63, 0, 0, 0, 2, 63, "jmp63");
        run(OP_ALU, 0, 0, 0, 0, 4, 0, "wrap");
        run(OP_JMP, 17, 0, 0, 0, 2, 17, "jmp17");

        bus.opcode = OP_HALT;
        imem_dly = 0;
        n = 0;
        while (bus.halted !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("halt latency", n, 2);
        bus.start = 1'b1;
        spur = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("halted sticky", bus.halted, 1);
        chk("halted pc", bus.pc, 17);
        chk("halted imem_req", bus.imem_req, 0);
        bus.start = 1'b0;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst clears halted", bus.halted, 0);
        chk("rst clears pc", bus.pc, 0);
        pulse_start();
        run(OP_JMP, 20, 0, 0, 0, 2, 20, "jmp20");
        bus.opcode = OP_LOAD;
        dmem_dly = 10;
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach mem", n, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid-mem rst dmem_req", bus.dmem_req, 0);
        chk("mid-mem rst pc", bus.pc, 0);
        chk("mid-mem rst imem_req", bus.imem_req, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle holds", bus.imem_req, 0);
        pulse_start();
        run(OP_ALU, 0, 0, 0, 0, 4, 1, "alu_after_rst");
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
